// File: rtl/rmc_enable_sequencer.sv
// Power-rail enable sequencer: ramps channel enables up in index order behind power-good,
// ramps them down in reverse order, and latches a sticky fault on any power-good loss or timeout.
module rmc_enable_sequencer #(
    parameter int          NUM_CH     = 4,
    parameter logic [15:0] STEP_DLY   = 16'd100,
    parameter logic [15:0] PG_TIMEOUT = 16'd500
) (
    input  logic              clk_in,
    input  logic              iRst,
    input  logic              iTick,
    input  logic              iEnable_req,
    input  logic [NUM_CH-1:0] iPgood,
    input  logic              iClear,
    output logic [NUM_CH-1:0] oEnable,
    output logic              oAll_on,
    output logic              oFault,
    output logic [2:0]        oState
);

    localparam int            KW     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NUM_CH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PWR_UP = 3'd1;
    localparam logic [2:0] ON     = 3'd2;
    localparam logic [2:0] PWR_DN = 3'd3;
    localparam logic [2:0] FAULT  = 3'd4;

    logic [2:0]        state;
    logic [2:0]        nextState;
    logic [KW-1:0]     stepK;
    logic [KW-1:0]     nextK;
    logic [15:0]       tickCnt;
    logic [NUM_CH-1:0] nextEnable;
    logic              stepEntry;
    logic              lowerLost;
    logic              upDone;
    logic              dnDone;
    logic              pgTimeout;

    assign oState = state;

    // Any already-enabled channel below the active step losing power-good is a fault.
    always_comb begin
        lowerLost = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if ((KW'(j) < stepK) && !iPgood[j]) begin
                lowerLost = 1'b1;
            end
        end
    end

    assign upDone    = iPgood[stepK] && (tickCnt >= STEP_DLY);
    assign pgTimeout = (tickCnt >= PG_TIMEOUT) && !iPgood[stepK];
    // A zero step delay still needs one tick on the way down so a stalled timebase freezes it.
    assign dnDone    = (STEP_DLY == 16'd0) ? (iTick || (tickCnt != 16'd0))
                                           : (tickCnt >= STEP_DLY);

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        nextState  = state;
        nextK      = stepK;
        nextEnable = oEnable;
        stepEntry  = 1'b0;

        case (state)
            IDLE: begin
                if (iEnable_req) begin
                    nextState     = PWR_UP;
                    nextK         = '0;
                    nextEnable[0] = 1'b1;
                    stepEntry     = 1'b1;
                end
            end
            PWR_UP: begin
                if (lowerLost || pgTimeout) begin
                    nextState = FAULT;
                end else if (!iEnable_req) begin
                    nextState         = PWR_DN;
                    nextEnable[stepK] = 1'b0;
                    stepEntry         = 1'b1;
                end else if (upDone) begin
                    stepEntry = 1'b1;
                    if (stepK == LAST_K) begin
                        nextState = ON;
                    end else begin
                        nextK             = stepK + 1'b1;
                        nextEnable[nextK] = 1'b1;
                    end
                end
            end
            ON: begin
                if (!(&iPgood)) begin
                    nextState = FAULT;
                end else if (!iEnable_req) begin
                    nextState          = PWR_DN;
                    nextK              = LAST_K;
                    nextEnable[LAST_K] = 1'b0;
                    stepEntry          = 1'b1;
                end
            end
            PWR_DN: begin
                if (dnDone) begin
                    stepEntry = 1'b1;
                    if (stepK == '0) begin
                        nextState = IDLE;
                    end else begin
                        nextK             = stepK - 1'b1;
                        nextEnable[nextK] = 1'b0;
                    end
                end
            end
            FAULT: begin
                if (iClear && !iEnable_req) begin
                    nextState = IDLE;
                end
            end
            default: nextState = FAULT;
        endcase

        if ((nextState == FAULT) || (nextState == IDLE)) begin
            nextEnable = '0;
        end
        if (nextState == IDLE) begin
            nextK = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk_in) begin
        if (iRst) begin
            state   <= IDLE;
            stepK   <= '0;
            tickCnt <= '0;
            oEnable <= '0;
            oAll_on <= 1'b0;
            oFault  <= 1'b0;
        end else begin
            state   <= nextState;
            stepK   <= nextK;
            oEnable <= nextEnable;
            oAll_on <= (nextState == ON);
            oFault  <= (nextState == FAULT);
            if (stepEntry) begin
                tickCnt <= '0;
            end else if (iTick && (tickCnt != 16'hFFFF)) begin
                tickCnt <= tickCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rmc_enable_sequencer.sv
// Directed bench for rmc_enable_sequencer: NUM_CH=4, STEP_DLY=4, PG_TIMEOUT=10, iTick every 2 cycles,
// with a load model that raises each power-good one tick after its enable.
module tb_rmc_enable_sequencer;

    localparam int NUM_CH = 4;

    logic              clk_in      = 1'b0;
    logic              iRst        = 1'b1;
    logic              iTick       = 1'b0;
    logic              iEnable_req = 1'b0;
    logic              iClear      = 1'b0;
    logic [NUM_CH-1:0] iPgood;
    logic [NUM_CH-1:0] oEnable;
    logic              oAll_on;
    logic              oFault;
    logic [2:0]        oState;

    logic [NUM_CH-1:0] enHist1   = '0;
    logic [NUM_CH-1:0] enHist2   = '0;
    logic [NUM_CH-1:0] pgoodKill = '0;

    int nChecks = 0;
    int nErrors = 0;

    wire [8:0] obsVec = {oFault, oAll_on, oState, oEnable};

    assign iPgood = enHist2 & ~pgoodKill;

    always #5 clk_in = ~clk_in;

    rmc_enable_sequencer #(
        .NUM_CH    (NUM_CH),
        .STEP_DLY  (16'd4),
        .PG_TIMEOUT(16'd10)
    ) dut (
        .clk_in     (clk_in),
        .iRst       (iRst),
        .iTick      (iTick),
        .iEnable_req(iEnable_req),
        .iPgood     (iPgood),
        .iClear     (iClear),
        .oEnable    (oEnable),
        .oAll_on    (oAll_on),
        .oFault     (oFault),
        .oState     (oState)
    );

    // Timebase strobe every second cycle, and a load whose power-good lags its enable by one tick.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            iTick   = ~iTick;
            enHist2 = enHist1;
            enHist1 = oEnable;
        end
    end

    function automatic logic [8:0] mk(input logic f, input logic a, input logic [2:0] s,
                                      input logic [3:0] e);
        return {f, a, s, e};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Advances at least one edge, then until the observed vector matches or the budget runs out.
    task automatic waitObs(input string tag, input logic [8:0] exp, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((obsVec !== exp) && (n < budget));
        check(tag, 32'(obsVec), 32'(exp));
    endtask

    task automatic rampUp(input string tag);
        int n;
        iEnable_req = 1'b1;
        waitObs({tag, "En0"}, mk(0, 0, 3'd1, 4'b0001), 4, n);
        check({tag, "Lat0"}, n, 1);
        waitObs({tag, "En1"}, mk(0, 0, 3'd1, 4'b0011), 20, n);
        check({tag, "Gap0"}, 32'((n == 8) || (n == 9)), 1);
        waitObs({tag, "En2"}, mk(0, 0, 3'd1, 4'b0111), 20, n);
        check({tag, "Gap1"}, n, 8);
        waitObs({tag, "En3"}, mk(0, 0, 3'd1, 4'b1111), 20, n);
        check({tag, "Gap2"}, n, 8);
        waitObs({tag, "On"}, mk(0, 1, 3'd2, 4'b1111), 20, n);
        check({tag, "Gap3"}, n, 8);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) tick();
        check("rstObs", 32'(obsVec), 0);
        iRst = 1'b0;
        repeat (2) tick();
        check("idleHold", 32'(obsVec), 0);

        // Full power-up then ordered power-down
        rampUp("up");
        iEnable_req = 1'b0;
        waitObs("dn3", mk(0, 0, 3'd3, 4'b0111), 4, n);
        check("dnLat", n, 1);
        waitObs("dn2", mk(0, 0, 3'd3, 4'b0011), 20, n);
        check("dnGap0", 32'((n == 8) || (n == 9)), 1);
        waitObs("dn1", mk(0, 0, 3'd3, 4'b0001), 20, n);
        check("dnGap1", n, 8);
        waitObs("dn0", mk(0, 0, 3'd3, 4'b0000), 20, n);
        check("dnGap2", n, 8);
        waitObs("dnIdle", mk(0, 0, 3'd0, 4'b0000), 20, n);
        check("dnGap3", n, 8);

        // Power-good timeout on channel 2, fault hold and clear
        pgoodKill   = 4'b0100;
        iEnable_req = 1'b1;
        waitObs("toEn0", mk(0, 0, 3'd1, 4'b0001), 4, n);
        waitObs("toEn1", mk(0, 0, 3'd1, 4'b0011), 20, n);
        waitObs("toEn2", mk(0, 0, 3'd1, 4'b0111), 20, n);
        waitObs("toFault", mk(1, 0, 3'd4, 4'b0000), 40, n);
        check("toGap", n, 20);
        iClear = 1'b1;
        repeat (4) tick();
        check("faultHeld", 32'(obsVec), 32'(mk(1, 0, 3'd4, 4'b0000)));
        iEnable_req = 1'b0;
        waitObs("faultExit", mk(0, 0, 3'd0, 4'b0000), 3, n);
        check("faultExitLat", n, 1);
        iClear    = 1'b0;
        pgoodKill = '0;
        repeat (4) tick();

        // Power-good loss while ON
        rampUp("up2");
        pgoodKill = 4'b0010;
        waitObs("onLoss", mk(1, 0, 3'd4, 4'b0000), 3, n);
        check("onLossLat", n, 1);
        iClear = 1'b1;
        iEnable_req = 1'b0;
        waitObs("onLossClr", mk(0, 0, 3'd0, 4'b0000), 3, n);
        iClear    = 1'b0;
        pgoodKill = '0;
        repeat (4) tick();

        // Abort at step 1, re-request ignored until IDLE
        iEnable_req = 1'b1;
        waitObs("abEn0", mk(0, 0, 3'd1, 4'b0001), 4, n);
        waitObs("abEn1", mk(0, 0, 3'd1, 4'b0011), 20, n);
        repeat (2) tick();
        iEnable_req = 1'b0;
        waitObs("abDn1", mk(0, 0, 3'd3, 4'b0001), 3, n);
        check("abLat", n, 1);
        iEnable_req = 1'b1;
        waitObs("abDn0", mk(0, 0, 3'd3, 4'b0000), 20, n);
        check("abGap0", 32'((n == 8) || (n == 9)), 1);
        waitObs("abIdle", mk(0, 0, 3'd0, 4'b0000), 20, n);
        check("abGap1", n, 8);
        waitObs("reqAfterIdle", mk(0, 0, 3'd1, 4'b0001), 3, n);
        check("reqAfterIdleLat", n, 1);

        // Reset mid power-up with three channels on
        waitObs("rmEn1", mk(0, 0, 3'd1, 4'b0011), 20, n);
        waitObs("rmEn2", mk(0, 0, 3'd1, 4'b0111), 20, n);
        iRst        = 1'b1;
        iEnable_req = 1'b0;
        waitObs("rstMid", mk(0, 0, 3'd0, 4'b0000), 3, n);
        check("rstMidLat", n, 1);
        iRst = 1'b0;
        repeat (3) tick();
        check("rstMidIdle", 32'(obsVec), 0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/rmc_enable_sequencer.md
RMC_ENABLE_SEQUENCER -- requirements
Module: rmc_enable_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of sequenced enable channels (range 2..8).
REQ-002 The block SHALL have parameter STEP_DLY, default 16'd100, giving the minimum iTick count per sequencing step.
REQ-003 The block SHALL have parameter PG_TIMEOUT, default 16'd500, giving the iTick count allowed for power-good per power-up step.
REQ-004 The block SHALL have ports: clk_in  input  1  sole clock.
REQ-005 iRst  input  1  reset: synchronous, active-high.
REQ-006 iTick  input  1  one-cycle timebase strobe, synchronous to clk_in.
REQ-007 iEnable_req  input  1  debounced request: 1 = power up, 0 = power down.
REQ-008 iPgood  input  NUM_CH  per-channel power-good, already synchronized.
REQ-009 iClear  input  1  fault clear.
REQ-010 oEnable  output  NUM_CH  per-channel enables, registered.
REQ-011 oAll_on  output  1  all channels on and good, registered.
REQ-012 oFault  output  1  sticky fault flag, registered.
REQ-013 oState  output  3  current FSM state encoding.

Function
REQ-014 The FSM SHALL have states IDLE=0, PWR_UP=1, ON=2, PWR_DN=3 and FAULT=4; codes 5-7 SHALL go to FAULT on the next cycle.
REQ-015 A 16-bit tick counter SHALL clear on every step entry, SHALL increment on iTick, and SHALL saturate at 16'hFFFF.
REQ-016 A step index k (0..NUM_CH-1) SHALL select the active channel.
REQ-017 In IDLE, oEnable SHALL be all 0; when iEnable_req=1, the FSM SHALL enter PWR_UP with k=0.
REQ-018 In PWR_UP, oEnable[k] SHALL be 1 from the first cycle of step k, and oEnable[j] for j<k SHALL stay 1.
REQ-019 A PWR_UP step SHALL complete in the cycle where iPgood[k]=1 and counter>=STEP_DLY; the next cycle SHALL have k+1, or the state ON if k=NUM_CH-1.
REQ-020 If counter>=PG_TIMEOUT and iPgood[k]=0 in PWR_UP, the FSM SHALL enter FAULT.
REQ-021 If iPgood[j]=0 for any j<k in PWR_UP, the FSM SHALL enter FAULT.
REQ-022 If iEnable_req=0 in PWR_UP, the FSM SHALL enter PWR_DN with k unchanged; this abort SHALL take priority over step completion in the same cycle, and fault SHALL take priority over the abort.
REQ-023 In ON, oAll_on SHALL be 1; in every other state it SHALL be 0.
REQ-024 In ON, any iPgood bit=0 SHALL enter FAULT; otherwise iEnable_req=0 SHALL enter PWR_DN with k=NUM_CH-1.
REQ-025 In PWR_DN, oEnable[k] SHALL clear in the first cycle of step k.
REQ-026 A PWR_DN step SHALL complete when counter>=STEP_DLY; the FSM SHALL then decrement k, or go to IDLE if k=0.
REQ-027 PWR_DN SHALL ignore iPgood and iEnable_req; a re-request SHALL be honoured only after IDLE is reached.
REQ-028 On FAULT entry, oEnable SHALL be all 0 and oFault=1 in the same registered update.
REQ-029 The FSM SHALL exit FAULT to IDLE only when iClear=1 and iEnable_req=0, clearing oFault on exit.
REQ-030 With iTick held at 0, no step SHALL complete, except a PWR_UP step when STEP_DLY=0 and iPgood[k]=1.
REQ-031 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-032 When iRst=1 at a clk_in edge, state SHALL be IDLE, k=0, counter=0, oEnable=0, oAll_on=0, oFault=0 and oState=0.
REQ-033 Reset mid-sequence, in any state, SHALL drop all enables in the following cycle, with no power-down ordering.
REQ-034 Reset SHALL take priority over every other input.

Verification (bench parameters: NUM_CH=4, STEP_DLY=4, PG_TIMEOUT=10, iTick every 2 cycles)
REQ-035 Bench SHALL cover: iEnable_req 0->1, each iPgood[k] asserted 1 tick after oEnable[k] -> oEnable steps 0001, 0011, 0111, 1111 about 4 ticks apart, then oAll_on=1 and oState=2.
REQ-036 Bench SHALL cover: from ON, iEnable_req=0 -> oEnable steps 0111, 0011, 0001, 0000 about 4 ticks apart, then oState=0.
REQ-037 Bench SHALL cover: iPgood[2] held 0 -> FAULT 10 ticks after oEnable[2] rises, oEnable=0000, oFault=1; iClear=1 with iEnable_req=1 -> FAULT is held; iClear=1 with iEnable_req=0 -> IDLE.
REQ-038 Bench SHALL cover: in ON, iPgood[1] drops -> next cycle oState=4, oEnable=0000.
REQ-039 Bench SHALL cover: iEnable_req dropped while k=1 in PWR_UP -> PWR_DN from k=1, oEnable 0001 then 0000, then IDLE; a re-request during PWR_DN has no effect until IDLE.
REQ-040 Bench SHALL cover: iRst=1 while oEnable=0111 -> next cycle all outputs are 0 and oState=0.
